// File: rtl/pr_led_sink.sv
// pr_led_sink: static-region consumer of the reconfigurable partition's LED bus.
// Filters the raw bus, freezes it while the partition is decoupled,
// re-qualifies it after reload and drives PWM-dimmed LED pins.
module pr_led_sink #(
  parameter int LED_W      = 2,
  parameter int STABLE_CYC = 16,
  parameter int PWM_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             decouple,
  input  logic [LED_W-1:0] rm_led,
  input  logic [PWM_W-1:0] duty,
  output logic [LED_W-1:0] led_pin,
  output logic             led_valid,
  output logic             decouple_ack,
  output logic [CNT_W-1:0] change_cnt
);

  localparam int STAB_W = $clog2(STABLE_CYC + 1);
  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYC);

  typedef enum logic [1:0] {
    SETTLE    = 2'd0,
    RUN       = 2'd1,
    DECOUPLED = 2'd2
  } state_t;

  // Stability counter saturates so a long-stable bus stays qualified.
  function automatic logic [STAB_W-1:0] stab_inc(input logic [STAB_W-1:0] v);
    return (v == STAB_MAX) ? v : v + 1'b1;
  endfunction

  // Change counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t             state;
  state_t             state_nxt;
  logic [LED_W-1:0]   r1_p0;
  logic [LED_W-1:0]   cand_p1;
  logic [STAB_W-1:0]  stab_p1;
  logic [LED_W-1:0]   accepted_p2;
  logic [PWM_W-1:0]   pwm_cnt;

  logic               stab_full;
  logic               is_new;
  logic               accept_en;
  logic               count_en;
  logic               restart;
  logic               valid_nxt;
  logic               ack_nxt;
  logic               pwm_on;

  assign stab_full = (stab_p1 == STAB_MAX);
  assign is_new    = (cand_p1 != accepted_p2);
  assign count_en  = accept_en & is_new;
  assign pwm_on    = (&duty) | (pwm_cnt < duty);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SETTLE;
    else        state <= state_nxt;
  end

  // Next-state logic: decouple always wins over a pending qualification.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:       if (decouple) state_nxt = DECOUPLED;
      DECOUPLED: if (!decouple) state_nxt = SETTLE;
      SETTLE: begin
        if (decouple)       state_nxt = DECOUPLED;
        else if (stab_full) state_nxt = RUN;
      end
      default:   state_nxt = SETTLE;
    endcase
  end

  // Control decode: accept strobes, window restart and next status flags.
  always_comb begin
    accept_en = 1'b0;
    restart   = 1'b0;
    valid_nxt = led_valid;
    ack_nxt   = decouple_ack;
    case (state)
      RUN: begin
        if (decouple) begin
          valid_nxt = 1'b0;
          ack_nxt   = 1'b1;
        end else if (stab_full && is_new) begin
          accept_en = 1'b1;
        end
      end
      DECOUPLED: begin
        if (!decouple) begin
          ack_nxt = 1'b0;
          restart = 1'b1;
        end else begin
          valid_nxt = 1'b0;
          ack_nxt   = 1'b1;
        end
      end
      SETTLE: begin
        if (decouple) begin
          valid_nxt = 1'b0;
          ack_nxt   = 1'b1;
        end else if (stab_full) begin
          accept_en = 1'b1;
          valid_nxt = 1'b1;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        ack_nxt   = 1'b0;
      end
    endcase
  end

  // Glitch filter: sample, track candidate and count consecutive matches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_p0   <= '0;
      cand_p1 <= '0;
      stab_p1 <= '0;
    end else begin
      r1_p0 <= rm_led;
      if (r1_p0 != cand_p1) cand_p1 <= r1_p0;
      if (restart)                stab_p1 <= '0;
      else if (r1_p0 == cand_p1)  stab_p1 <= stab_inc(stab_p1);
      else                        stab_p1 <= STAB_W'(1);
    end
  end

  // Accepted value and its change counter; frozen outside accept strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accepted_p2 <= '0;
      change_cnt  <= '0;
    end else begin
      if (accept_en) accepted_p2 <= cand_p1;
      if (count_en)  change_cnt  <= cnt_inc(change_cnt);
    end
  end

  // Status flags toward the static region.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_valid    <= 1'b0;
      decouple_ack <= 1'b0;
    end else begin
      led_valid    <= valid_nxt;
      decouple_ack <= ack_nxt;
    end
  end

  // Free-running PWM and registered pin drive of the accepted value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      led_pin <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      led_pin <= accepted_p2 & {LED_W{pwm_on}};
    end
  end

endmodule

// File: tb/tb_pr_led_sink.sv
// Bench for pr_led_sink: directed vector table, hand-written corner sequences
// and a randomized run compared against a window-based reference model.
module tb_pr_led_sink;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       decouple = 1'b0;
  logic [1:0] rm_led = 2'b00;
  logic [7:0] duty = 8'hFF;

  logic [1:0]  pin0, pin1;
  logic        val0, val1, ack0, ack1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pr_led_sink #(.LED_W(2), .STABLE_CYC(16), .PWM_W(8), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .decouple(decouple), .rm_led(rm_led), .duty(duty),
    .led_pin(pin0), .led_valid(val0), .decouple_ack(ack0), .change_cnt(cnt0));

  pr_led_sink #(.LED_W(2), .STABLE_CYC(4), .PWM_W(8), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .decouple(decouple), .rm_led(rm_led), .duty(duty),
    .led_pin(pin1), .led_valid(val1), .decouple_ack(ack1), .change_cnt(cnt1));

  // Reference model: a value is qualified when the last N samples seen by the
  // filter, all taken since the last window restart, are identical.
  int ns   [2] = '{16, 4};
  int cmax [2] = '{65535, 3};
  int hist [2][16];
  int histn [2];
  int m_r1 [2], m_acc [2], m_cnt [2], m_pwm [2], m_pin [2];
  bit m_valid [2], m_ack [2], m_dec [2];

  typedef struct {
    bit         dec;
    logic [1:0] rm;
    logic [7:0] duty;
    int         cyc;
    bit         rnd;
    logic [1:0] pin;
    bit         valid;
    bit         ack;
    int         cnt;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    histn[k] = 0;
    m_r1[k] = 0; m_acc[k] = 0; m_cnt[k] = 0; m_pwm[k] = 0; m_pin[k] = 0;
    m_valid[k] = 0; m_ack[k] = 0; m_dec[k] = 0;
  endtask

  task automatic model_edge(input int k);
    bit qual;
    bit rel;
    int qv;
    int newpin;
    qual = (histn[k] >= ns[k]);
    qv = hist[k][0];
    for (int i = 0; i < ns[k]; i++)
      if (hist[k][i] != qv) qual = 0;
    rel = 0;
    newpin = (duty == 8'hFF || m_pwm[k] < int'(duty)) ? m_acc[k] : 0;
    if (decouple) begin
      if (!m_dec[k]) begin
        m_dec[k] = 1; m_ack[k] = 1; m_valid[k] = 0;
      end
    end else if (m_dec[k]) begin
      m_dec[k] = 0; m_ack[k] = 0; rel = 1;
    end else if (qual) begin
      if (qv != m_acc[k]) begin
        m_acc[k] = qv;
        if (m_cnt[k] < cmax[k]) m_cnt[k]++;
      end
      m_valid[k] = 1;
    end
    m_pin[k] = newpin;
    m_pwm[k] = (m_pwm[k] + 1) % 256;
    for (int i = 15; i > 0; i--) hist[k][i] = hist[k][i-1];
    hist[k][0] = m_r1[k];
    if (histn[k] < 16) histn[k]++;
    if (rel) histn[k] = 0;
    m_r1[k] = int'(rm_led);
  endtask

  function automatic int act_of(input int k);
    if (k == 0) return int'({cnt0, pin0, val0, ack0});
    return int'({cnt1, pin1, val1, ack1});
  endfunction

  function automatic int exp_of(input int k);
    return (m_cnt[k] << 4) | (m_pin[k] << 2) | (int'(m_valid[k]) << 1) | int'(m_ack[k]);
  endfunction

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k);
    #1;
    for (int k = 0; k < 2; k++)
      chk($sformatf("model%0d t=%0t {cnt,pin,valid,ack}", k, $time), act_of(k), exp_of(k));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) model_reset(k);
    chk("rst_pin0", pin0, 0);  chk("rst_valid0", val0, 0);
    chk("rst_ack0", ack0, 0);  chk("rst_cnt0", cnt0, 0);
    chk("rst_pin1", pin1, 0);  chk("rst_valid1", val1, 0);
    chk("rst_ack1", ack1, 0);  chk("rst_cnt1", cnt1, 0);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      decouple = tbl[i].dec;
      rm_led   = tbl[i].rm;
      duty     = tbl[i].duty;
      for (int c = 0; c < tbl[i].cyc; c++) begin
        if (tbl[i].rnd) rm_led = 2'($urandom);
        step();
      end
      chk($sformatf("row%0d_pin", i),   pin0, tbl[i].pin);
      chk($sformatf("row%0d_valid", i), val0, tbl[i].valid);
      chk($sformatf("row%0d_ack", i),   ack0, tbl[i].ack);
      chk($sformatf("row%0d_cnt", i),   cnt0, tbl[i].cnt);
    end
  endtask

  initial begin
    int hi0, hi1;
    logic [1:0] seq [5];

    // Expected outputs of the 16-sample instance after each row.
    tbl[0]  = '{0, 2'b11, 8'hFF, 17, 0, 2'b00, 0, 0, 0};
    tbl[1]  = '{0, 2'b11, 8'hFF,  1, 0, 2'b00, 1, 0, 1};
    tbl[2]  = '{0, 2'b11, 8'hFF,  1, 0, 2'b11, 1, 0, 1};
    tbl[3]  = '{0, 2'b00, 8'hFF,  5, 0, 2'b11, 1, 0, 1};
    tbl[4]  = '{0, 2'b11, 8'hFF, 20, 0, 2'b11, 1, 0, 1};
    tbl[5]  = '{1, 2'b11, 8'hFF,  1, 0, 2'b11, 0, 1, 1};
    tbl[6]  = '{1, 2'b11, 8'hFF, 40, 1, 2'b11, 0, 1, 1};
    tbl[7]  = '{0, 2'b01, 8'hFF,  1, 0, 2'b11, 0, 0, 1};
    tbl[8]  = '{0, 2'b01, 8'hFF, 16, 0, 2'b11, 0, 0, 1};
    tbl[9]  = '{0, 2'b01, 8'hFF,  1, 0, 2'b11, 1, 0, 2};
    tbl[10] = '{0, 2'b01, 8'hFF,  1, 0, 2'b01, 1, 0, 2};
    tbl[11] = '{0, 2'b11, 8'hFF, 17, 0, 2'b01, 1, 0, 2};
    tbl[12] = '{0, 2'b11, 8'hFF,  1, 0, 2'b01, 1, 0, 3};
    tbl[13] = '{0, 2'b11, 8'hFF,  1, 0, 2'b11, 1, 0, 3};
    tbl[14] = '{0, 2'b10, 8'hFF, 17, 0, 2'b11, 1, 0, 3};
    tbl[15] = '{1, 2'b10, 8'hFF,  1, 0, 2'b11, 0, 1, 3};
    tbl[16] = '{1, 2'b10, 8'hFF,  1, 0, 2'b11, 0, 1, 3};
    tbl[17] = '{0, 2'b11, 8'hFF,  1, 0, 2'b11, 0, 0, 3};
    tbl[18] = '{0, 2'b11, 8'hFF, 16, 0, 2'b11, 0, 0, 3};
    tbl[19] = '{0, 2'b11, 8'hFF,  1, 0, 2'b11, 1, 0, 3};

    for (int k = 0; k < 2; k++) model_reset(k);
    rm_led = 2'b11;
    duty = 8'hFF;
    @(posedge clk);
    #1;
    do_reset();

    // Power-up qualification, glitch rejection, decouple and re-settle.
    run_rows(0, 13);

    // Quarter duty: each bit high for exactly 64 of 256 cycles.
    duty = 8'd64;
    hi0 = 0;
    hi1 = 0;
    repeat (256) begin
      step();
      hi0 += int'(pin0[0]);
      hi1 += int'(pin0[1]);
    end
    chk("duty64_bit0_high", hi0, 64);
    chk("duty64_bit1_high", hi1, 64);

    duty = 8'd0;
    step();
    repeat (20) begin
      step();
      chk("duty0_pin", pin0, 0);
    end

    // Decouple on the very cycle a new value would qualify.
    run_rows(14, 19);

    // Saturating change counter on the narrow instance, then async reset in SETTLE.
    rm_led = 2'b01;
    #2;
    do_reset();
    seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
    for (int i = 0; i < 5; i++) begin
      rm_led = seq[i];
      repeat (8) step();
    end
    chk("sat_cnt1", cnt1, 3);
    chk("sat_pin1_before_rst", pin1, 1);
    decouple = 1'b1;
    step();
    decouple = 1'b0;
    repeat (2) step();
    chk("settle_valid1", val1, 0);
    #2;
    do_reset();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0) rm_led = 2'($urandom);
      if ($urandom_range(39) == 0) decouple = ~decouple;
      if ($urandom_range(49) == 0) begin
        case ($urandom_range(2))
          0:       duty = 8'd0;
          1:       duty = 8'hFF;
          default: duty = 8'($urandom);
        endcase
      end
      step();
      if ($urandom_range(599) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
